// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and parity helper for the UART TX controller.
package uart_pkg;

  localparam int DATA_W          = 7;
  localparam int FRAME_BITS      = 10;
  localparam int CLK_DIV_DEFAULT = 434;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and pulses tick on the last count.
module uart_baud_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: accepts 7-bit words, computes parity, paces one 10-bit frame.
// Define UART_TX_HOLD_BUF_EN to add a one-entry holding buffer for gapless frames.
// Handshake: a word transfers on any clk edge where tx_valid && tx_ready are both high.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_bit,
  output logic              load_data,
  output logic              shift_en,
  output logic              baud_tick,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              accept;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .en_i    (state_q == ST_SHIFT),
    .clr_i   (state_q != ST_SHIFT),
    .tick_o  (baud_tick)
  );

  assign frame_done = (state_q == ST_SHIFT) && baud_tick && (bit_cnt_q == LAST_BIT);
  assign load_data  = (state_q == ST_LOAD);
  assign shift_en   = (state_q == ST_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign data_out   = data_q;
  assign parity_bit = par_q;
  assign dbg_state  = state_q;
  assign accept     = tx_valid && tx_ready;

`ifdef UART_TX_HOLD_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              buf_par_q, buf_par_d;

  assign tx_ready = !buf_valid_q;
`else
  assign tx_ready = (state_q == ST_IDLE);
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_HOLD_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_par_d   = buf_par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = tx_data;
          par_d   = calc_parity(tx_data, parity_odd);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frame_done) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
`ifdef UART_TX_HOLD_BUF_EN
          // A pending word (buffered or arriving now) chains straight into LOAD.
          if (buf_valid_q) begin
            data_d      = buf_data_q;
            par_d       = buf_par_q;
            buf_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end else if (accept) begin
            data_d  = tx_data;
            par_d   = calc_parity(tx_data, parity_odd);
            state_d = ST_LOAD;
          end
`endif
        end else if (baud_tick) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UART_TX_HOLD_BUF_EN
    if (accept && (state_q != ST_IDLE) && !frame_done) begin
      buf_valid_d = 1'b1;
      buf_data_d  = tx_data;
      buf_par_d   = calc_parity(tx_data, parity_odd);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
`ifdef UART_TX_HOLD_BUF_EN
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      buf_par_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_HOLD_BUF_EN
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_par_q   <= buf_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (CLK_DIV=4) with a behavioural TX shift register driving txd.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CLK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              parity_odd = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] data_out;
  logic              parity_bit, load_data, shift_en, baud_tick, busy, frame_done;
  logic [1:0]        dbg_state;

  logic [9:0] sr_q;
  logic       txd;
  logic [0:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  uart_tx_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .parity_odd (parity_odd),
    .data_out   (data_out),
    .parity_bit (parity_bit),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .baud_tick  (baud_tick),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // Shift register: frame is {stop, parity, data, start}, LSB on the line first.
  always_ff @(posedge clk) begin
    if (!rst_n)         sr_q <= 10'h3FF;
    else if (load_data) sr_q <= {1'b1, parity_bit, data_out, 1'b0};
    else if (baud_tick) sr_q <= {1'b1, sr_q[9:1]};
  end
  assign txd = sr_q[0];

  // driver tasks
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({load_data, shift_en, baud_tick, frame_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_pulses: got %b want 0000", {load_data, shift_en, baud_tick, frame_done}); end
    n_cmp++; if ({data_out, parity_bit} !== 8'h00) begin
      n_err++; $display("FAIL reset_data: got %h want 00", {data_out, parity_bit}); end
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", txd); end
    drive_point();
    rst_n = 1'b1;
  endtask

  // Starts and ends at a drive point with the controller in IDLE.
  task automatic test_frame(input string name, input logic [DATA_W-1:0] data, input logic podd,
                            input logic [9:0] exp_bits, input logic exp_par);
    logic [0:0] cur;
    tx_valid = 1'b1; tx_data = data; parity_odd = podd;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %b want 1", name, tx_ready); end
    drive_point();
    tx_valid = 1'b0; tx_data = 7'h7F; parity_odd = ~podd;
    @(negedge clk);
    n_cmp++; if (load_data !== 1'b1) begin n_err++; $display("FAIL %s_load: got %b want 1", name, load_data); end
    n_cmp++; if (data_out !== data) begin n_err++; $display("FAIL %s_data_out: got %h want %h", name, data_out, data); end
    n_cmp++; if (parity_bit !== exp_par) begin n_err++; $display("FAIL %s_parity: got %b want %b", name, parity_bit, exp_par); end
    for (int k = 0; k < 10; k++) exp_q.push_back(exp_bits[k]);
    cur = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CLK_DIV; j++) begin
        @(negedge clk);
        if (j == 0) cur = exp_q.pop_front();
        n_cmp++; if (txd !== cur[0]) begin n_err++; $display("FAIL %s_txd bit %0d: got %b want %b", name, k, txd, cur[0]); end
        n_cmp++; if (baud_tick !== (j == CLK_DIV-1)) begin
          n_err++; $display("FAIL %s_tick bit %0d cyc %0d: got %b want %b", name, k, j, baud_tick, j == CLK_DIV-1); end
        n_cmp++; if (frame_done !== (k == 9 && j == CLK_DIV-1)) begin
          n_err++; $display("FAIL %s_done bit %0d cyc %0d: got %b", name, k, j, frame_done); end
      end
    end
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s_end_idle: got ready=%b busy=%b want 1/0", name, tx_ready, busy); end
    drive_point();
  endtask

  task automatic test_reset_mid();
    int ticks = 0;
    int budget = 0;
    tx_valid = 1'b1; tx_data = 7'h41; parity_odd = 1'b0;
    drive_point();
    tx_valid = 1'b0;
    while (ticks < 5 && budget < 200) begin
      @(negedge clk);
      if (baud_tick) ticks++;
      budget++;
    end
    n_cmp++; if (ticks !== 5) begin n_err++; $display("FAIL mid_ticks: got %0d want 5", ticks); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tx_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL mid_reset_state: got busy=%b ready=%b st=%0d want 0/1/0", busy, tx_ready, dbg_state); end
    n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL mid_reset_txd: got %b want 1", txd); end
    n_cmp++; if (frame_done !== 1'b0 || shift_en !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_pulses: got done=%b shift=%b want 0/0", frame_done, shift_en); end
    drive_point();
    rst_n = 1'b1;
    test_frame("after_reset", 7'h2A, 1'b0, 10'h354, 1'b1);
  endtask

`ifndef UART_TX_HOLD_BUF_EN
  task automatic test_hold_off();
    int b = 0;
    tx_valid = 1'b1; tx_data = 7'h41; parity_odd = 1'b0;
    drive_point();
    tx_data = 7'h2A; parity_odd = 1'b1;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready cyc %0d: got %b want 0", i, tx_ready); end
      n_cmp++; if (data_out !== 7'h41 || parity_bit !== 1'b0) begin
        n_err++; $display("FAIL hold_data cyc %0d: got %h/%b want 41/0", i, data_out, parity_bit); end
      if (i == 40) begin
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL hold_done: got %b want 1", frame_done); end
      end
    end
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL hold_idle: got ready=%b busy=%b want 1/0", tx_ready, busy); end
    drive_point();
    tx_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (load_data !== 1'b1) begin n_err++; $display("FAIL hold_second_load: got %b want 1", load_data); end
    n_cmp++; if (data_out !== 7'h2A || parity_bit !== 1'b0) begin
      n_err++; $display("FAIL hold_second_data: got %h/%b want 2a/0", data_out, parity_bit); end
    while (busy && b < 100) begin @(negedge clk); b++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_finish: got busy=%b want 0", busy); end
    drive_point();
  endtask
`else
  task automatic test_back_to_back();
    logic [9:0] f1 = 10'h2AA;
    logic [9:0] f2 = 10'h354;
    tx_valid = 1'b1; tx_data = 7'h55; parity_odd = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", tx_ready); end
    drive_point();
    tx_data = 7'h2A;
    @(negedge clk);
    n_cmp++; if (load_data !== 1'b1 || data_out !== 7'h55 || parity_bit !== 1'b0) begin
      n_err++; $display("FAIL b2b_load1: got %b/%h/%b want 1/55/0", load_data, data_out, parity_bit); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", tx_ready); end
    drive_point();
    tx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full cyc %0d: got %b want 0", i, tx_ready); end
      n_cmp++; if (txd !== f1[i/CLK_DIV] || data_out !== 7'h55) begin
        n_err++; $display("FAIL b2b_f1 cyc %0d: got txd=%b data=%h want %b/55", i, txd, data_out, f1[i/CLK_DIV]); end
      n_cmp++; if (frame_done !== (i == 39)) begin n_err++; $display("FAIL b2b_done1 cyc %0d: got %b", i, frame_done); end
    end
    @(negedge clk);
    n_cmp++; if (load_data !== 1'b1 || data_out !== 7'h2A || parity_bit !== 1'b1 || tx_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_load2: got %b/%h/%b/%b want 1/2a/1/1", load_data, data_out, parity_bit, tx_ready); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++; if (txd !== f2[i/CLK_DIV]) begin n_err++; $display("FAIL b2b_f2 cyc %0d: got %b want %b", i, txd, f2[i/CLK_DIV]); end
      n_cmp++; if (frame_done !== (i == 39)) begin n_err++; $display("FAIL b2b_done2 cyc %0d: got %b", i, frame_done); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: got busy=%b ready=%b want 0/1", busy, tx_ready); end
    drive_point();
  endtask
`endif

  initial begin
    test_reset();
    test_frame("even", 7'h41, 1'b0, 10'h282, 1'b0);
    test_frame("odd",  7'h41, 1'b1, 10'h382, 1'b1);
    test_reset_mid();
`ifdef UART_TX_HOLD_BUF_EN
    test_back_to_back();
`else
    test_hold_off();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
